// File: rtl/cci_mpf_svc_vtp_client_mux_if.sv
// Signal bundle for the VTP client mux: client side, server side and drain control.
// The mux takes the slave view; the surrounding pipeline takes the master view.
interface cci_mpf_svc_vtp_client_mux_if #(
   parameter int N_CLIENTS       = 4,
   parameter int MAX_REQS        = 16,
   parameter int VA_IDX_BITS     = 36,
   parameter int PA_IDX_BITS     = 36,
   parameter int CLIENT_TAG_BITS = 4
);
   localparam int TAG_W = $clog2(MAX_REQS);
   localparam int CNT_W = $clog2(MAX_REQS + 1);

   logic [N_CLIENTS-1:0]                 c_lookupEn;
   logic [N_CLIENTS*VA_IDX_BITS-1:0]     c_lookupVA;
   logic [N_CLIENTS-1:0]                 c_lookupSpec;
   logic [N_CLIENTS*CLIENT_TAG_BITS-1:0] c_lookupTag;
   logic [N_CLIENTS-1:0]                 c_lookupRdy;
   logic [N_CLIENTS-1:0]                 c_rspValid;
   logic [PA_IDX_BITS-1:0]               c_rspPA;
   logic                                 c_rspError;
   logic                                 c_rspIsBigPage;
   logic [CLIENT_TAG_BITS-1:0]           c_rspTag;

   logic                                 s_lookupEn;
   logic [VA_IDX_BITS-1:0]               s_lookupVA;
   logic                                 s_lookupSpec;
   logic [TAG_W-1:0]                     s_lookupTag;
   logic                                 s_lookupRdy;
   logic                                 s_rspValid;
   logic [PA_IDX_BITS-1:0]               s_rspPA;
   logic                                 s_rspError;
   logic                                 s_rspIsBigPage;
   logic [TAG_W-1:0]                     s_rspTag;

   logic                                 drainReq;
   logic                                 drainDone;
   logic [CNT_W-1:0]                     numOutstanding;
   logic                                 errUnexpTag;

   modport slave (
      input  c_lookupEn, c_lookupVA, c_lookupSpec, c_lookupTag,
      output c_lookupRdy,
      output c_rspValid, c_rspPA, c_rspError, c_rspIsBigPage, c_rspTag,
      output s_lookupEn, s_lookupVA, s_lookupSpec, s_lookupTag,
      input  s_lookupRdy,
      input  s_rspValid, s_rspPA, s_rspError, s_rspIsBigPage, s_rspTag,
      input  drainReq,
      output drainDone, numOutstanding, errUnexpTag
   );

   modport master (
      output c_lookupEn, c_lookupVA, c_lookupSpec, c_lookupTag,
      input  c_lookupRdy,
      input  c_rspValid, c_rspPA, c_rspError, c_rspIsBigPage, c_rspTag,
      input  s_lookupEn, s_lookupVA, s_lookupSpec, s_lookupTag,
      output s_lookupRdy,
      output s_rspValid, s_rspPA, s_rspError, s_rspIsBigPage, s_rspTag,
      output drainReq,
      input  drainDone, numOutstanding, errUnexpTag
   );
endinterface

// File: rtl/cci_mpf_svc_vtp_client_mux.sv
// N-client round-robin front end for the shared VTP translation service.
// Allocates service tags from a free pool and routes responses back by tag.
module cci_mpf_svc_vtp_client_mux #(
   parameter int N_CLIENTS       = 4,
   parameter int MAX_REQS        = 16,
   parameter int VA_IDX_BITS     = 36,
   parameter int PA_IDX_BITS     = 36,
   parameter int CLIENT_TAG_BITS = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   cci_mpf_svc_vtp_client_mux_if.slave bus
);
   localparam int TAG_W = $clog2(MAX_REQS);
   localparam int CNT_W = $clog2(MAX_REQS + 1);
   localparam int ID_W  = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

   logic [MAX_REQS-1:0]        busy_q, busy_d;
   logic [ID_W-1:0]            tid_q [MAX_REQS];
   logic [CLIENT_TAG_BITS-1:0] ttag_q [MAX_REQS];
   logic [ID_W-1:0]            rr_q, rr_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [N_CLIENTS-1:0]       rv_q, rv_d;
   logic [PA_IDX_BITS-1:0]     pa_q, pa_d;
   logic                       er_q, er_d;
   logic                       big_q, big_d;
   logic [CLIENT_TAG_BITS-1:0] rtag_q, rtag_d;
   logic                       err_q, err_d;
   logic                       dd_q, dd_d;

   logic                       found;
   logic [ID_W-1:0]            win;
   logic [ID_W-1:0]            idx;
   logic                       any_free;
   logic [TAG_W-1:0]           alloc;
   logic                       elig;
   logic                       gnt;
   logic                       hit;
   logic                       unexp;
   logic [CLIENT_TAG_BITS-1:0] win_tag;

   // First requester at or after the RR pointer, wrapping.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < N_CLIENTS; k++) begin
         idx = ID_W'((int'(rr_q) + k) % N_CLIENTS);
         if (!found && bus.c_lookupEn[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      any_free = 1'b0;
      alloc    = '0;
      for (int t = MAX_REQS - 1; t >= 0; t--) begin
         if (!busy_q[t]) begin
            any_free = 1'b1;
            alloc    = TAG_W'(t);
         end
      end
   end

   assign elig    = bus.s_lookupRdy & any_free & ~bus.drainReq & ~reset;
   assign gnt     = elig & found;
   assign win_tag = bus.c_lookupTag[win*CLIENT_TAG_BITS +: CLIENT_TAG_BITS];

   assign bus.c_lookupRdy  = gnt ? (N_CLIENTS'(1) << win) : '0;
   assign bus.s_lookupEn   = gnt;
   assign bus.s_lookupVA   = bus.c_lookupVA[win*VA_IDX_BITS +: VA_IDX_BITS];
   assign bus.s_lookupSpec = bus.c_lookupSpec[win];
   assign bus.s_lookupTag  = alloc;

   assign hit   = bus.s_rspValid &  busy_q[bus.s_rspTag];
   assign unexp = bus.s_rspValid & ~busy_q[bus.s_rspTag];

   // Freed and allocated tags never collide: alloc comes from busy_q.
   always_comb begin
      busy_d = busy_q;
      if (hit) busy_d[bus.s_rspTag] = 1'b0;
      if (gnt) busy_d[alloc] = 1'b1;

      cnt_d = cnt_q;
      case ({gnt, hit})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      rr_d = rr_q;
      if (gnt) begin
         rr_d = (int'(win) == N_CLIENTS - 1) ? '0 : win + ID_W'(1);
      end

      rv_d   = '0;
      pa_d   = pa_q;
      er_d   = er_q;
      big_d  = big_q;
      rtag_d = rtag_q;
      if (hit) begin
         rv_d   = N_CLIENTS'(1) << tid_q[bus.s_rspTag];
         pa_d   = bus.s_rspPA;
         er_d   = bus.s_rspError;
         big_d  = bus.s_rspIsBigPage;
         rtag_d = ttag_q[bus.s_rspTag];
      end

      err_d = err_q | unexp;
      dd_d  = bus.drainReq & (cnt_d == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
         cnt_q  <= '0;
         rr_q   <= '0;
         rv_q   <= '0;
         pa_q   <= '0;
         er_q   <= 1'b0;
         big_q  <= 1'b0;
         rtag_q <= '0;
         err_q  <= 1'b0;
         dd_q   <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         rr_q   <= rr_d;
         rv_q   <= rv_d;
         pa_q   <= pa_d;
         er_q   <= er_d;
         big_q  <= big_d;
         rtag_q <= rtag_d;
         err_q  <= err_d;
         dd_q   <= dd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (gnt) begin
         tid_q[alloc]  <= win;
         ttag_q[alloc] <= win_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(gnt && !hit && cnt_q == CNT_W'(MAX_REQS)));
         assert (!(hit && !gnt && cnt_q == '0));
      end
   end

   assign bus.c_rspValid     = rv_q;
   assign bus.c_rspPA        = pa_q;
   assign bus.c_rspError     = er_q;
   assign bus.c_rspIsBigPage = big_q;
   assign bus.c_rspTag       = rtag_q;
   assign bus.drainDone      = dd_q;
   assign bus.numOutstanding = cnt_q;
   assign bus.errUnexpTag    = err_q;
endmodule

// File: tb/tb_cci_mpf_svc_vtp_client_mux.sv
// Bench for the VTP client mux: directed scenarios plus random traffic
// checked every cycle against a tag-pool / round-robin reference model.
module tb_cci_mpf_svc_vtp_client_mux;
   localparam int N    = 4;
   localparam int MAXR = 16;
   localparam int VAW  = 36;
   localparam int PAW  = 36;
   localparam int CTW  = 4;
   localparam int TW   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cci_mpf_svc_vtp_client_mux_if #(
      .N_CLIENTS(N), .MAX_REQS(MAXR), .VA_IDX_BITS(VAW),
      .PA_IDX_BITS(PAW), .CLIENT_TAG_BITS(CTW)
   ) bus ();

   cci_mpf_svc_vtp_client_mux #(
      .N_CLIENTS(N), .MAX_REQS(MAXR), .VA_IDX_BITS(VAW),
      .PA_IDX_BITS(PAW), .CLIENT_TAG_BITS(CTW)
   ) dut (
      .clk(clk),
      .reset(rst),
      .bus(bus.slave)
   );

   int nchk = 0;
   int nerr = 0;

   bit             req_en   [N];
   logic [VAW-1:0] req_va   [N];
   bit             req_spec [N];
   logic [CTW-1:0] req_tag  [N];
   bit             srdy, rsp_v, drain;
   int             rsp_t;
   logic [PAW-1:0] rsp_pa;
   bit             rsp_er, rsp_big;

   // Reference model: tag pool, per-tag owner, RR pointer, counters.
   bit             m_busy [MAXR];
   int             m_cli  [MAXR];
   int             m_ctag [MAXR];
   int             m_rr, m_cnt;
   bit             m_err, m_dd;
   logic [N-1:0]   e_rv;
   logic [PAW-1:0] e_pa;
   bit             e_er, e_big;
   int             e_tag;
   bit             g;
   int             gw, gt;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      logic [N-1:0]     en;
      logic [N-1:0]     sp;
      logic [N*VAW-1:0] va;
      logic [N*CTW-1:0] tg;
      for (int i = 0; i < N; i++) begin
         en[i] = req_en[i];
         sp[i] = req_spec[i];
         va[i*VAW +: VAW] = req_va[i];
         tg[i*CTW +: CTW] = req_tag[i];
      end
      bus.c_lookupEn     = en;
      bus.c_lookupSpec   = sp;
      bus.c_lookupVA     = va;
      bus.c_lookupTag    = tg;
      bus.s_lookupRdy    = srdy;
      bus.s_rspValid     = rsp_v;
      bus.s_rspTag       = TW'(rsp_t);
      bus.s_rspPA        = rsp_pa;
      bus.s_rspError     = rsp_er;
      bus.s_rspIsBigPage = rsp_big;
      bus.drainReq       = drain;
   endtask

   function automatic void predict();
      g  = 1'b0;
      gw = 0;
      gt = 0;
      if (rst || !srdy || drain || m_cnt == MAXR) return;
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m_rr + k) % N;
         if (req_en[c]) begin
            g  = 1'b1;
            gw = c;
            break;
         end
      end
      if (!g) return;
      for (int i = 0; i < MAXR; i++) begin
         if (!m_busy[i]) begin
            gt = i;
            break;
         end
      end
   endfunction

   function automatic void update();
      if (rst) begin
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_rr  = 0;
         m_cnt = 0;
         m_err = 1'b0;
         m_dd  = 1'b0;
         e_rv  = '0;
         return;
      end
      e_rv = '0;
      if (rsp_v) begin
         if (m_busy[rsp_t]) begin
            e_rv  = N'(1) << m_cli[rsp_t];
            e_pa  = rsp_pa;
            e_er  = rsp_er;
            e_big = rsp_big;
            e_tag = m_ctag[rsp_t];
            m_busy[rsp_t] = 1'b0;
            m_cnt--;
         end else begin
            m_err = 1'b1;
         end
      end
      if (g) begin
         m_busy[gt] = 1'b1;
         m_cli[gt]  = gw;
         m_ctag[gt] = int'(req_tag[gw]);
         m_rr       = (gw + 1) % N;
         m_cnt++;
      end
      m_dd = drain && (m_cnt == 0);
   endfunction

   task automatic cycle();
      drive();
      @(negedge clk);
      predict();
      chk("lookupRdy", 64'(bus.c_lookupRdy), g ? (64'd1 << gw) : 64'd0);
      chk("s_lookupEn", 64'(bus.s_lookupEn), 64'(g));
      if (g) begin
         chk("s_lookupTag", 64'(bus.s_lookupTag), 64'(gt));
         chk("s_lookupVA", 64'(bus.s_lookupVA), 64'(req_va[gw]));
         chk("s_lookupSpec", 64'(bus.s_lookupSpec), 64'(req_spec[gw]));
      end
      chk("rspValid", 64'(bus.c_rspValid), 64'(e_rv));
      if (e_rv != '0) begin
         chk("rspPA", 64'(bus.c_rspPA), 64'(e_pa));
         chk("rspError", 64'(bus.c_rspError), 64'(e_er));
         chk("rspBig", 64'(bus.c_rspIsBigPage), 64'(e_big));
         chk("rspTag", 64'(bus.c_rspTag), 64'(e_tag));
      end
      chk("numOutstanding", 64'(bus.numOutstanding), 64'(m_cnt));
      chk("errUnexpTag", 64'(bus.errUnexpTag), 64'(m_err));
      chk("drainDone", 64'(bus.drainDone), 64'(m_dd));
      update();
      @(posedge clk);
      #1;
      if (g) req_en[gw] = 1'b0;
      rsp_v = 1'b0;
   endtask

   task automatic req(int c, int tag);
      req_en[c]   = 1'b1;
      req_va[c]   = VAW'({$urandom(), $urandom()});
      req_spec[c] = 1'($urandom_range(1, 0));
      req_tag[c]  = CTW'(tag);
   endtask

   task automatic respond(int t);
      rsp_v   = 1'b1;
      rsp_t   = t;
      rsp_pa  = PAW'({$urandom(), $urandom()});
      rsp_er  = 1'($urandom_range(1, 0));
      rsp_big = 1'($urandom_range(1, 0));
   endtask

   task automatic flush();
      for (int i = 0; i < N; i++) req_en[i] = 1'b0;
      for (int n = 0; n < 2 * MAXR && m_cnt > 0; n++) begin
         for (int t = 0; t < MAXR; t++) begin
            if (m_busy[t]) begin
               respond(t);
               break;
            end
         end
         cycle();
      end
      chk("flush_empty", 64'(bus.numOutstanding), 64'd0);
      cycle();
   endtask

   initial begin
      bit pg;
      int pt;
      e_rv  = '0;
      srdy  = 1'b0;
      rsp_v = 1'b0;
      drain = 1'b0;
      rsp_t = 0;
      rsp_pa = '0;
      for (int i = 0; i < N; i++) begin
         req_en[i] = 1'b0;
         req_va[i] = '0;
         req_spec[i] = 1'b0;
         req_tag[i] = '0;
      end

      // Reset state, with a pending request that must not be granted.
      req(0, 1);
      srdy = 1'b1;
      drive();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdy", 64'(bus.c_lookupRdy), 64'd0);
      chk("rst_outst", 64'(bus.numOutstanding), 64'd0);
      chk("rst_rspValid", 64'(bus.c_rspValid), 64'd0);
      chk("rst_err", 64'(bus.errUnexpTag), 64'd0);
      chk("rst_drainDone", 64'(bus.drainDone), 64'd0);
      cycle();
      rst = 1'b0;
      req_en[0] = 1'b0;
      cycle();

      // Single lookup and response.
      req(0, 5);
      req_va[0] = 36'h123;
      drive();
      #1;
      chk("t1_tag", 64'(bus.s_lookupTag), 64'd0);
      chk("t1_va", 64'(bus.s_lookupVA), 64'h123);
      cycle();
      chk("t1_outst1", 64'(bus.numOutstanding), 64'd1);
      respond(0);
      rsp_pa = 36'hABC;
      cycle();
      chk("t1_rv", 64'(bus.c_rspValid), 64'h1);
      chk("t1_pa", 64'(bus.c_rspPA), 64'hABC);
      chk("t1_ctag", 64'(bus.c_rspTag), 64'd5);
      chk("t1_outst0", 64'(bus.numOutstanding), 64'd0);
      cycle();

      // All clients busy, instant responses: round-robin rotation.
      pg = 1'b0;
      pt = 0;
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < N; i++) if (!req_en[i]) req(i, c);
         if (pg) respond(pt);
         cycle();
         pg = g;
         pt = gt;
      end
      flush();

      // Fill all tags, then a freed tag is the next one allocated.
      for (int c = 0; c < MAXR; c++) begin
         for (int i = 0; i < N; i++) if (!req_en[i]) req(i, c);
         cycle();
      end
      drive();
      #1;
      chk("t3_full_rdy", 64'(bus.c_lookupRdy), 64'd0);
      chk("t3_full_cnt", 64'(bus.numOutstanding), 64'd16);
      respond(7);
      cycle();
      drive();
      #1;
      chk("t3_reuse7", 64'(bus.s_lookupTag), 64'd7);
      cycle();
      flush();

      // Out-of-order responses.
      req(2, 10);
      cycle();
      req(0, 3);
      cycle();
      respond(1);
      cycle();
      chk("t4_rv_c0", 64'(bus.c_rspValid), 64'b0001);
      chk("t4_tag_c0", 64'(bus.c_rspTag), 64'd3);
      respond(0);
      cycle();
      chk("t4_rv_c2", 64'(bus.c_rspValid), 64'b0100);
      chk("t4_tag_c2", 64'(bus.c_rspTag), 64'd10);
      flush();

      // Drain with three outstanding.
      req(0, 1);
      req(1, 2);
      req(2, 3);
      repeat (3) cycle();
      req(3, 4);
      req(0, 5);
      drain = 1'b1;
      repeat (3) cycle();
      for (int r = 0; r < 3; r++) begin
         for (int t = 0; t < MAXR; t++) begin
            if (m_busy[t]) begin
               respond(t);
               break;
            end
         end
         cycle();
      end
      chk("t5_drainDone", 64'(bus.drainDone), 64'd1);
      chk("t5_outst", 64'(bus.numOutstanding), 64'd0);
      drain = 1'b0;
      drive();
      #1;
      chk("t5_resume", 64'(bus.s_lookupEn), 64'd1);
      cycle();
      flush();

      // Random traffic with out-of-order responses and drain toggles.
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_en[i] && $urandom_range(1, 0) == 1) begin
               req(i, int'($urandom_range(15, 0)));
            end
         end
         srdy = ($urandom_range(3, 0) != 0);
         if ($urandom_range(15, 0) == 0) drain = ~drain;
         if (m_cnt > 0 && $urandom_range(1, 0) == 1) begin
            int k;
            k = int'($urandom_range(MAXR - 1, 0));
            while (!m_busy[k]) k = (k + 1) % MAXR;
            respond(k);
         end
         cycle();
      end
      drain = 1'b0;
      srdy = 1'b1;
      flush();

      // Unexpected tag, then reset mid-flight.
      respond(9);
      cycle();
      chk("t6_err", 64'(bus.errUnexpTag), 64'd1);
      chk("t6_norv", 64'(bus.c_rspValid), 64'd0);
      req(1, 6);
      req(2, 7);
      repeat (3) cycle();
      chk("t6_err_sticky", 64'(bus.errUnexpTag), 64'd1);
      rst = 1'b1;
      req(3, 8);
      repeat (2) cycle();
      rst = 1'b0;
      chk("t6_rst_outst", 64'(bus.numOutstanding), 64'd0);
      chk("t6_rst_err", 64'(bus.errUnexpTag), 64'd0);
      drive();
      #1;
      chk("t6_rst_tag0", 64'(bus.s_lookupTag), 64'd0);
      cycle();
      flush();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
